delay_sweep_ctrl: RTL and testbench
===================================

Name: delay_sweep_ctrl

Overview:
- Wishbone-slave sequencer that automates the delay-line sweep for one measurement channel.
- Steps the 10-bit delay code from START to STOP in STEP increments.
- At each point it fires REPS strobes, samples the comparator after each strobe and counts hits.
- Each {code, hits} pair is pushed into a result FIFO that the CPU pops over Wishbone. Mapped in the crossbar next to the measure unit.

Parameters:
- LG_FIFO, 3, log2 of result FIFO depth (depth 8).
- SYNC_STAGES, 2, comparator synchronizer flops (min 2).

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  32  byte address; only [4:2] decoded.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte selects; ignored, writes are full-word.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  acknowledge.
- wb_stall_o  out  1  tied 0.
- wb_err_o  out  1  tied 0.
- delay_code_o  out  10  delay-line code.
- stb_o  out  1  one-cycle strobe to the delay line.
- cmp_i  in  1  asynchronous comparator output.
- busy_o  out  1  sweep in progress.
- done_irq_o  out  1  one-cycle pulse at sweep completion or abort.

Behaviour:
- Reset values: all outputs 0; registers 0; FIFO empty; state IDLE; done flag 0.
- Wishbone: ack is registered, high exactly one cycle after cyc&stb; ack is not reissued while stb is held. Read data is valid with ack.
- Register map (word offsets):
  - 0 CTRL. Write bit0 = start, accepted only in IDLE; it clears done, flushes the FIFO and latches the config. Write bit1 = abort. Read: bit0 busy, bit1 done (sticky), bit2 fifo_empty, bit3 fifo_full, bits[7:4] state.
  - 1 RANGE: start [9:0], stop [25:16].
  - 2 STEP: [9:0]; a value of 0 is treated as 1.
  - 3 REPS: [15:0]; 0 is treated as 1.
  - 4 TIMING: settle [15:0], sample_dly [31:16].
  - 5 RESULT. Read pops the FIFO and returns bit31 = 1, code [25:16], hits [15:0]. A read when empty returns 0 and does not pop.
  - Other offsets: read 0, writes ignored.
- Config registers are writable anytime; a running sweep uses the copies latched at start.
- FSM:
  - IDLE: on start, code <= start, rep <= 0, hits <= 0 -> SETTLE.
  - SETTLE: delay_code_o = code; wait settle cycles (0 = none) -> STROBE.
  - STROBE: stb_o = 1 for one cycle -> SAMPLE.
  - SAMPLE: wait sample_dly cycles, then hits += synced cmp. rep+1 < reps -> STROBE; else -> STORE.
  - STORE: if FIFO not full, push {code, hits}, then compute next = code + step at 11 bits. next > stop or next[10] -> DONE; else code <= next, hits <= 0, rep <= 0 -> SETTLE. If the FIFO is full, hold in STORE with busy high.
  - DONE: set done, pulse done_irq_o for one cycle -> IDLE.
- busy_o = (state != IDLE && state != DONE).
- start > stop: exactly one point (start) is measured, then DONE.
- hits saturates at 16'hFFFF.
- Abort from any non-IDLE state: next cycle goes to DONE. The in-progress point is discarded; FIFO contents are kept; delay_code_o holds its last value.
- Simultaneous pop and push in STORE when the FIFO is full: the pop takes effect first and the push succeeds in the same cycle.
- Asynchronous reset mid-sweep: immediate return to reset values; no irq pulse.
- cmp_i passes through SYNC_STAGES flops before sampling. The bench must allow for this latency via sample_dly.

Test Plan:
- Basic sweep: start=0, stop=4, step=2, reps=3, settle=2, cmp_i=1, then start. Required: 9 stb_o pulses, FIFO holds (0,3), (2,3), (4,3), one done_irq_o pulse, done=1, busy=0.
- Hit counting: reps=10, cmp_i toggles so it is high at 4 of 10 samples. Required: the single point reads back hits=4. Reading RESULT again returns 0.
- Backpressure: LG_FIFO=3, start=0, stop=9, step=1, no reads. Required: 8 entries pushed, FSM holds in STORE with busy=1 and fifo_full=1. One RESULT read lets sweep resume; after draining, all 10 codes 0..9 are received in order.
- Top-of-range overflow: start=1020, stop=1023, step=2. Required: codes 1020 and 1022 only, then DONE with no wrap to low codes. Also step=0 -> step 1 behaviour; start=5, stop=3 -> one entry (5, n).
- Abort/start-while-busy: start a long sweep, then write start again. Required: ignored, config unchanged. Abort at point 3. Required: done_irq within 2 cycles, FIFO holds points 0..2, busy=0.
- Reset mid-sweep: assert wb_rst_ni low during SAMPLE. Required: stb_o, delay_code_o, busy_o and ack immediately 0; FIFO empty; no irq. A fresh sweep afterwards behaves as in the basic sweep.

Source files
------------

// File: rtl/delay_sweep_ctrl.sv
// Wishbone sequencer sweeping a 10-bit delay code, strobing REPS times per point and queueing {code, hits}.
// Bus ack one cycle after a new request; the sweep holds in STORE while the result FIFO is full.

module delay_sweep_ctrl #(
    parameter int LG_FIFO     = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_stall_o,
    output logic        wb_err_o,
    output logic [9:0]  delay_code_o,
    output logic        stb_o,
    input  logic        cmp_i,
    output logic        busy_o,
    output logic        done_irq_o
);

    localparam int DEPTH = 1 << LG_FIFO;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_STROBE = 3'd2,
        S_SAMPLE = 3'd3,
        S_STORE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t state;

    // programmable configuration, visible on the bus
    logic [9:0]  cfg_start, cfg_stop, cfg_step;
    logic [15:0] cfg_reps, cfg_settle, cfg_sdly;

    // copies frozen at start for the running sweep
    logic [9:0]  run_stop, run_step;
    logic [15:0] run_reps, run_settle, run_sdly;

    logic [9:0]  code;
    logic [15:0] rep, hits, cnt;
    logic        stb, irq, done;

    logic [SYNC_STAGES-1:0] sync;
    logic                   cmp_s;

    logic [25:0]        mem [DEPTH];
    logic [LG_FIFO:0]   wr_ptr, rd_ptr;
    logic               fifo_empty, fifo_full;

    logic               req, req_q, access, wr, rd;
    logic [2:0]         offs;
    logic               ack;
    logic [31:0]        dat, rd_data;

    logic               start_req, abort_req, pop, push;
    logic [10:0]        next_code;
    logic [16:0]        rep_nxt;
    logic               unused;

    assign unused = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0]};

    // one access per stb assertion: a held strobe does not re-trigger
    assign req    = wb_cyc_i & wb_stb_i;
    assign access = req & ~req_q;
    assign wr     = access & wb_we_i;
    assign rd     = access & ~wb_we_i;
    assign offs   = wb_adr_i[4:2];

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[LG_FIFO] != rd_ptr[LG_FIFO]) &&
                        (wr_ptr[LG_FIFO-1:0] == rd_ptr[LG_FIFO-1:0]);

    assign start_req = wr && (offs == 3'd0) && wb_dat_i[0] && (state == S_IDLE);
    assign abort_req = wr && (offs == 3'd0) && wb_dat_i[1] &&
                       (state != S_IDLE) && (state != S_DONE);
    assign pop       = rd && (offs == 3'd5) && !fifo_empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign push      = (state == S_STORE) && !abort_req && (!fifo_full || pop);

    assign next_code = {1'b0, code} + {1'b0, run_step};
    assign rep_nxt   = {1'b0, rep} + 17'd1;
    assign cmp_s     = sync[SYNC_STAGES-1];

    assign wb_dat_o     = dat;
    assign wb_ack_o     = ack;
    assign wb_stall_o   = 1'b0;
    assign wb_err_o     = 1'b0;
    assign delay_code_o = code;
    assign stb_o        = stb;
    assign done_irq_o   = irq;
    assign busy_o       = (state != S_IDLE) && (state != S_DONE);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], cmp_i};
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (offs)
            3'd0: rd_data = {24'd0, 1'b0, state, fifo_full, fifo_empty, done, busy_o};
            3'd1: rd_data = {6'd0, cfg_stop, 6'd0, cfg_start};
            3'd2: rd_data = {22'd0, cfg_step};
            3'd3: rd_data = {16'd0, cfg_reps};
            3'd4: rd_data = {cfg_sdly, cfg_settle};
            3'd5: rd_data = fifo_empty ? 32'd0 : {1'b1, 5'd0, mem[rd_ptr[LG_FIFO-1:0]]};
            default: rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            req_q <= 1'b0;
            ack   <= 1'b0;
            dat   <= 32'd0;
        end else begin
            req_q <= req;
            ack   <= access;
            dat   <= rd ? rd_data : 32'd0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cfg_start  <= '0;
            cfg_stop   <= '0;
            cfg_step   <= '0;
            cfg_reps   <= '0;
            cfg_settle <= '0;
            cfg_sdly   <= '0;
        end else if (wr) begin
            case (offs)
                3'd1: begin
                    cfg_start <= wb_dat_i[9:0];
                    cfg_stop  <= wb_dat_i[25:16];
                end
                3'd2: cfg_step <= wb_dat_i[9:0];
                3'd3: cfg_reps <= wb_dat_i[15:0];
                3'd4: begin
                    cfg_settle <= wb_dat_i[15:0];
                    cfg_sdly   <= wb_dat_i[31:16];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr[LG_FIFO-1:0]] <= {code, hits};
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (start_req) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (LG_FIFO+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (LG_FIFO+1)'(1);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= S_IDLE;
            code       <= '0;
            rep        <= '0;
            hits       <= '0;
            cnt        <= '0;
            stb        <= 1'b0;
            irq        <= 1'b0;
            done       <= 1'b0;
            run_stop   <= '0;
            run_step   <= '0;
            run_reps   <= '0;
            run_settle <= '0;
            run_sdly   <= '0;
        end else begin
            stb <= 1'b0;
            irq <= 1'b0;
            if (abort_req) begin
                state <= S_DONE;
                cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_req) begin
                            run_stop   <= cfg_stop;
                            run_step   <= (cfg_step == 10'd0) ? 10'd1 : cfg_step;
                            run_reps   <= (cfg_reps == 16'd0) ? 16'd1 : cfg_reps;
                            run_settle <= cfg_settle;
                            run_sdly   <= cfg_sdly;
                            code       <= cfg_start;
                            rep        <= '0;
                            hits       <= '0;
                            cnt        <= '0;
                            done       <= 1'b0;
                            state      <= S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (cnt >= run_settle) begin
                            cnt   <= '0;
                            stb   <= 1'b1;
                            state <= S_STROBE;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    S_STROBE: begin
                        cnt   <= '0;
                        state <= S_SAMPLE;
                    end
                    S_SAMPLE: begin
                        if (cnt >= run_sdly) begin
                            cnt <= '0;
                            if (cmp_s && (hits != 16'hFFFF)) hits <= hits + 16'd1;
                            if (rep_nxt < {1'b0, run_reps}) begin
                                rep   <= rep_nxt[15:0];
                                stb   <= 1'b1;
                                state <= S_STROBE;
                            end else begin
                                state <= S_STORE;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    S_STORE: begin
                        if (push) begin
                            // 11-bit sum: carry out means the top of the delay range was passed
                            if (next_code[10] || (next_code > {1'b0, run_stop})) begin
                                state <= S_DONE;
                            end else begin
                                code  <= next_code[9:0];
                                hits  <= '0;
                                rep   <= '0;
                                cnt   <= '0;
                                state <= S_SETTLE;
                            end
                        end
                    end
                    S_DONE: begin
                        done  <= 1'b1;
                        irq   <= 1'b1;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_delay_sweep_ctrl.sv
// Bench for delay_sweep_ctrl: random sweeps against a point-list model, scoreboarded RESULT reads and strobe codes.
module tb_delay_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [31:0] wb_adr = 32'd0, wb_wdat = 32'd0;
    logic [3:0]  wb_sel = 4'd0;
    logic [31:0] wb_rdat;
    logic        wb_ack, wb_stall, wb_err;
    logic [9:0]  code;
    logic        stb, busy, irq;
    logic        cmp = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_rd_q[$];
    logic [9:0]  exp_code_q[$];
    bit          pat[4096];
    int          stb_idx = 0, stb_cnt = 0, irq_cnt = 0, cyc_cnt = 0, irq_cyc = 0;
    bit          stb_chk_en = 1'b0;

    always #5 clk = ~clk;

    delay_sweep_ctrl #(.LG_FIFO(3), .SYNC_STAGES(2)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_wdat), .wb_sel_i(wb_sel),
        .wb_dat_o(wb_rdat), .wb_ack_o(wb_ack), .wb_stall_o(wb_stall), .wb_err_o(wb_err),
        .delay_code_o(code), .stb_o(stb), .cmp_i(cmp),
        .busy_o(busy), .done_irq_o(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    // monitor: RESULT reads against the scoreboard, strobe codes, comparator drive, irq pulses
    initial forever begin
        @(negedge clk);
        if (wb_ack && !wb_we && (wb_adr[4:2] == 3'd5)) begin
            if (exp_rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL result_unexpected: got 0x%08h with nothing expected", wb_rdat);
            end else begin
                chk("result", wb_rdat, exp_rd_q.pop_front());
            end
        end
        if (stb) begin
            stb_cnt++;
            if (stb_chk_en) begin
                if (exp_code_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL stb_unexpected: strobe at code %0d with none expected", code);
                end else begin
                    chk("stb_code", {22'd0, code}, {22'd0, exp_code_q.pop_front()});
                end
            end
            cmp = pat[stb_idx % 4096];
            stb_idx++;
        end
        if (irq) begin
            irq_cnt++;
            irq_cyc = cyc_cnt;
        end
    end

    task automatic wait_ack(output logic [31:0] d);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        d = 32'd0;
        while (!got && n < 8) begin
            @(posedge clk);
            #1;
            n++;
            if (wb_ack) begin
                got = 1'b1;
                d = wb_rdat;
            end
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL wb_ack_timeout: no ack within 8 cycles, expected ack");
        end
    endtask

    task automatic wb_write(input logic [2:0] off, input logic [31:0] d);
        logic [31:0] dummy;
        @(posedge clk);
        #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_adr = {27'd0, off, 2'b00}; wb_wdat = d; wb_sel = 4'hF;
        wait_ack(dummy);
    endtask

    task automatic wb_read(input logic [2:0] off, output logic [31:0] d);
        @(posedge clk);
        #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
        wb_adr = {27'd0, off, 2'b00}; wb_sel = 4'hF;
        wait_ack(d);
    endtask

    // reference: list of measured points from start/stop/step rules, hits summed from the per-strobe pattern
    function automatic int model(input int st, input int sp, input int stp, input int rp,
                                 input int max_pts, input int max_rd);
        int s, r, c, k, g, h;
        logic [31:0] cv;
        bit more;
        s = (stp == 0) ? 1 : stp;
        r = (rp == 0) ? 1 : rp;
        c = st; k = 0; g = 0; more = 1'b1;
        while (more && k < max_pts) begin
            cv = c;
            h = 0;
            for (int j = 0; j < r; j++) begin
                exp_code_q.push_back(cv[9:0]);
                h += int'(pat[g]);
                g++;
            end
            if (h > 65535) h = 65535;
            if (k < max_rd) exp_rd_q.push_back({1'b1, 5'd0, cv[9:0], h[15:0]});
            k++;
            if ((c + s > sp) || (c + s > 1023)) more = 1'b0;
            else c = c + s;
        end
        return k;
    endfunction

    task automatic setup(input int st, input int sp, input int stp, input int rp,
                         input int settle, input int sdly, input int mode,
                         input int max_pts, input int max_rd, output int npts);
        logic [31:0] a, b, c2, d2, e, f;
        int ones, p;
        a = st; b = sp; c2 = stp; d2 = rp; e = settle; f = sdly;
        wb_write(3'd1, {6'd0, b[9:0], 6'd0, a[9:0]});
        wb_write(3'd2, {22'd0, c2[9:0]});
        wb_write(3'd3, {16'd0, d2[15:0]});
        wb_write(3'd4, {f[15:0], e[15:0]});
        for (int i = 0; i < 4096; i++) pat[i] = (mode == 1) ? 1'b1 : ((mode == 2) ? 1'b0 : 1'($urandom));
        if (mode == 2) begin
            ones = 0;
            while (ones < 4) begin
                p = $urandom_range(0, 9);
                if (!pat[p]) begin
                    pat[p] = 1'b1;
                    ones++;
                end
            end
        end
        exp_code_q.delete();
        stb_idx = 0;
        stb_chk_en = 1'b1;
        npts = model(st, sp, stp, rp, max_pts, max_rd);
    endtask

    task automatic wait_irq(input int prev, input int budget, input string name);
        int n;
        n = 0;
        while (irq_cnt == prev && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (irq_cnt == prev) begin
            failures++;
            $display("FAIL %s: done_irq count %0d, expected %0d within %0d cycles", name, irq_cnt, prev + 1, budget);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic drain(input int n);
        logic [31:0] d;
        for (int i = 0; i < n; i++) wb_read(3'd5, d);
    endtask

    task automatic poll_ctrl(input logic [31:0] want, input int budget, output logic [31:0] got);
        int n;
        n = 0;
        got = 32'hFFFF_FFFF;
        while (got != want && n < budget) begin
            wb_read(3'd0, got);
            n++;
        end
    endtask

    // start a sweep and check strobe count, single irq and full readback of the queued points
    task automatic run_full(input int st, input int sp, input int stp, input int rp,
                            input int settle, input int sdly, input int mode, input string name);
        int n, s0, i0, r;
        logic [31:0] d;
        r = (rp == 0) ? 1 : rp;
        setup(st, sp, stp, rp, settle, sdly, mode, 9999, 9999, n);
        s0 = stb_cnt;
        i0 = irq_cnt;
        wb_write(3'd0, 32'd1);
        wait_irq(i0, 20000, name);
        chk({name, "_stb_count"}, stb_cnt - s0, n * r);
        chk({name, "_irq_count"}, irq_cnt - i0, 1);
        chk({name, "_busy"}, {31'd0, busy}, 0);
        wb_read(3'd0, d);
        chk({name, "_ctrl"}, d, (n == 8) ? 32'h0A : 32'h02);
        drain(n);
        exp_rd_q.push_back(32'd0);
        wb_read(3'd5, d);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation still running at 900us, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        int n, s0, i0, a_cyc, st, sp, stp, s, rp, w;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {24'd0, wb_ack, wb_stall, wb_err, stb, busy, irq, 2'd0}, 0);
        chk("rst_code", {22'd0, code}, 0);
        chk("rst_dat", wb_rdat, 0);
        rst_n = 1'b1;
        wb_read(3'd0, d);
        chk("rst_ctrl", d, 32'h04);

        // basic sweep: (0,3) (2,3) (4,3)
        run_full(0, 4, 2, 3, 2, 4, 1, "basic");

        // hit counting: exactly 4 of 10 samples high
        setup(7, 7, 1, 10, 1, 3, 2, 9999, 9999, n);
        i0 = irq_cnt;
        wb_write(3'd0, 32'd1);
        wait_irq(i0, 2000, "hits");
        wb_read(3'd5, d);
        chk("hits4", {16'd0, d[15:0]}, 4);
        exp_rd_q.push_back(32'd0);
        wb_read(3'd5, d);
        chk("hits_empty_read", d, 0);

        // randomised sweeps of up to 8 points
        for (int it = 0; it < 8; it++) begin
            st  = $urandom_range(0, 1023);
            stp = $urandom_range(0, 150);
            s   = (stp == 0) ? 1 : stp;
            if ($urandom_range(0, 3) == 0) sp = $urandom_range(0, st);
            else begin
                sp = st + $urandom_range(0, 7 * s);
                if (sp > 1023) sp = 1023;
            end
            rp = $urandom_range(0, 5);
            run_full(st, sp, stp, rp, $urandom_range(0, 3), $urandom_range(2, 5), 0, "rand");
        end

        // range edges
        run_full(1020, 1023, 2, 2, 0, 2, 0, "top_range");
        run_full(10, 13, 0, 1, 0, 2, 0, "step0");
        run_full(5, 3, 1, 3, 1, 2, 0, "start_gt_stop");

        // backpressure: 10 points into an 8-deep FIFO
        setup(0, 9, 1, 1, 0, 2, 0, 9999, 9999, n);
        i0 = irq_cnt;
        wb_write(3'd0, 32'd1);
        poll_ctrl(32'h49, 100, d);
        chk("bp_full_ctrl", d, 32'h49);
        chk("bp_busy", {31'd0, busy}, 1);
        chk("bp_no_irq", irq_cnt - i0, 0);
        wb_read(3'd5, d);
        poll_ctrl(32'h49, 100, d);
        chk("bp_full_again", d, 32'h49);
        wb_read(3'd5, d);
        wait_irq(i0, 2000, "bp_done");
        drain(8);
        wb_read(3'd0, d);
        chk("bp_ctrl_end", d, 32'h06);

        // start-while-busy is ignored, then abort during point 3
        setup(0, 1023, 1, 4, 1, 6, 0, 4, 3, n);
        s0 = stb_cnt;
        i0 = irq_cnt;
        wb_write(3'd0, 32'd1);
        repeat (5) @(posedge clk);
        wb_write(3'd1, {6'd0, 10'd600, 6'd0, 10'd500});
        wb_write(3'd0, 32'd1);
        w = 0;
        while ((stb_cnt - s0) < 13 && w < 2000) begin
            @(posedge clk);
            w++;
        end
        chk("abort_reached_pt3", ((stb_cnt - s0) >= 13) ? 32'd1 : 32'd0, 1);
        wb_write(3'd0, 32'd2);
        a_cyc = cyc_cnt;
        wait_irq(i0, 4, "abort_irq");
        chk("abort_irq_latency", ((irq_cyc - a_cyc) <= 2) ? 32'd1 : 32'd0, 1);
        stb_chk_en = 1'b0;
        exp_code_q.delete();
        chk("abort_busy", {31'd0, busy}, 0);
        wb_read(3'd0, d);
        chk("abort_ctrl", d, 32'h02);
        drain(3);
        exp_rd_q.push_back(32'd0);
        wb_read(3'd5, d);

        // asynchronous reset in SAMPLE
        setup(100, 110, 5, 2, 1, 20, 1, 9999, 9999, n);
        s0 = stb_cnt;
        wb_write(3'd0, 32'd1);
        w = 0;
        while (stb_cnt == s0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        repeat (3) @(posedge clk);
        chk("pre_rst_code", {22'd0, code}, 100);
        i0 = irq_cnt;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {27'd0, stb, busy, wb_ack, irq, 1'b0}, 0);
        chk("rst_mid_code", {22'd0, code}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_mid_no_irq", irq_cnt - i0, 0);
        stb_chk_en = 1'b0;
        exp_code_q.delete();
        exp_rd_q.delete();
        wb_read(3'd0, d);
        chk("rst_mid_ctrl", d, 32'h04);
        run_full(0, 4, 2, 3, 2, 4, 1, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
